// File: rtl/router_pkt_pkg.sv
// Shared definitions for the router packet receive path: header layout,
// length limits, receiver FSM states and a header packing helper.
package router_pkt_pkg;

   localparam int LEN_MSB    = 7;
   localparam int LEN_LSB    = 2;
   localparam int ADDR_MSB   = 1;
   localparam int ADDR_LSB   = 0;
   localparam int MAX_LEN    = 63;
   // Router soft-resets a port left unread this many cycles.
   localparam int RD_TIMEOUT = 30;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      HDR,
      HCAP,
      PLD
   } rx_state_e;

   // Build a header byte from a length and destination address.
   function automatic logic [7:0] pack_hdr(input logic [5:0] len, input logic [1:0] addr);
      logic [7:0] h;
      h = 8'h00;
      h[LEN_MSB:LEN_LSB]   = len;
      h[ADDR_MSB:ADDR_LSB] = addr;
      return h;
   endfunction

endpackage

// File: rtl/router_pkt_rx.sv
// Destination-side packet receiver: drains one router output FIFO,
// splits header / payload / parity, streams payload and flags errors.
module router_pkt_rx
   import router_pkt_pkg::*;
#(
   parameter logic [1:0] ADDR_ID  = 2'd0,
   parameter int         RD_DELAY = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       valid_out,
   input  logic [7:0] data_out,
   output logic       read_enb,
   input  logic       enable,
   output logic [7:0] pld_data,
   output logic       pld_valid,
   output logic       pkt_done,
   output logic [5:0] pkt_len,
   output logic       parity_err,
   output logic       addr_err,
   output logic       pkt_drop,
   output logic       rx_busy
);

   localparam logic [5:0] DLY_INIT = 6'(RD_DELAY);

   rx_state_e  r_state;
   rx_state_e  w_next_state;
   logic [5:0] r_dly_cnt;
   logic [6:0] r_reads_left;   // up to len+1 = 64
   logic [5:0] r_cap_cnt;
   logic       r_cap_vld;      // a read fired last cycle; data_out holds its byte
   logic [7:0] r_par_acc;
   logic [7:0] r_pld_data;
   logic       r_pld_valid;
   logic       r_pkt_done;
   logic [5:0] r_pkt_len;
   logic       r_parity_err;
   logic       r_addr_err;
   logic       r_pkt_drop;
   logic       w_read_enb;
   logic       w_cap_last;

   // Read request follows valid_out/enable combinationally so a pause costs no byte.
   always_comb begin
      w_read_enb = ((r_state == HDR) || (r_state == PLD)) && valid_out && enable
                   && (r_reads_left != 7'd0);
      w_cap_last = r_cap_vld && (r_cap_cnt == r_pkt_len);
   end

   // Next-state selection.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (valid_out) w_next_state = WAIT;
         WAIT:    if (!valid_out) w_next_state = IDLE;
                  else if (r_dly_cnt == 6'd0) w_next_state = HDR;
         HDR:     if (w_read_enb) w_next_state = HCAP;
         HCAP:    w_next_state = PLD;
         PLD:     if (w_cap_last) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   // Counters, header/payload capture, parity accumulation and status pulses.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_dly_cnt    <= '0;
         r_reads_left <= '0;
         r_cap_cnt    <= '0;
         r_cap_vld    <= 1'b0;
         r_par_acc    <= '0;
         r_pld_data   <= '0;
         r_pld_valid  <= 1'b0;
         r_pkt_done   <= 1'b0;
         r_pkt_len    <= '0;
         r_parity_err <= 1'b0;
         r_addr_err   <= 1'b0;
         r_pkt_drop   <= 1'b0;
      end else begin
         r_pld_valid <= 1'b0;
         r_pkt_done  <= 1'b0;
         r_pkt_drop  <= 1'b0;
         r_cap_vld   <= (r_state == PLD) && w_read_enb;
         case (r_state)
            IDLE: if (valid_out) r_dly_cnt <= DLY_INIT;
            WAIT: begin
               if (!valid_out)              r_pkt_drop   <= 1'b1;
               else if (r_dly_cnt != 6'd0)  r_dly_cnt    <= r_dly_cnt - 6'd1;
               else                         r_reads_left <= 7'd1;
            end
            HDR: if (w_read_enb) r_reads_left <= r_reads_left - 7'd1;
            HCAP: begin
               r_pkt_len    <= data_out[LEN_MSB:LEN_LSB];
               r_addr_err   <= (data_out[ADDR_MSB:ADDR_LSB] != ADDR_ID);
               r_par_acc    <= data_out;
               r_reads_left <= {1'b0, data_out[LEN_MSB:LEN_LSB]} + 7'd1;
               r_cap_cnt    <= '0;
            end
            PLD: begin
               if (w_read_enb) r_reads_left <= r_reads_left - 7'd1;
               if (r_cap_vld) begin
                  if (r_cap_cnt != r_pkt_len) begin
                     r_pld_data  <= data_out;
                     r_pld_valid <= 1'b1;
                     r_par_acc   <= r_par_acc ^ data_out;
                     r_cap_cnt   <= r_cap_cnt + 6'd1;
                  end else begin
                     r_parity_err <= (r_par_acc != data_out);
                     r_pkt_done   <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign read_enb   = w_read_enb;
   assign pld_data   = r_pld_data;
   assign pld_valid  = r_pld_valid;
   assign pkt_done   = r_pkt_done;
   assign pkt_len    = r_pkt_len;
   assign parity_err = r_parity_err;
   assign addr_err   = r_addr_err;
   assign pkt_drop   = r_pkt_drop;
   assign rx_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_router_pkt_rx.sv
// Directed bench for router_pkt_rx: a byte-queue router model feeds the
// receiver; payload, status pulses and read gating are checked.
module tb_router_pkt_rx;
   import router_pkt_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   always #5 clock = ~clock;

   // dut0: ADDR_ID=0, RD_DELAY=0
   logic       valid_out, enable, read_enb;
   logic [7:0] data_out, pld_data;
   logic       pld_valid, pkt_done, parity_err, addr_err, pkt_drop, rx_busy;
   logic [5:0] pkt_len;
   // dut2: ADDR_ID=0, RD_DELAY=2
   logic       v2, read_enb2, pld_valid2, pkt_done2, parity_err2, addr_err2, pkt_drop2, rx_busy2;
   logic [7:0] d2, pld_data2;
   logic [5:0] pkt_len2;

   router_pkt_rx #(.ADDR_ID(2'd0), .RD_DELAY(0)) dut0 (
      .clock(clock), .reset(reset), .valid_out(valid_out), .data_out(data_out),
      .read_enb(read_enb), .enable(enable), .pld_data(pld_data), .pld_valid(pld_valid),
      .pkt_done(pkt_done), .pkt_len(pkt_len), .parity_err(parity_err), .addr_err(addr_err),
      .pkt_drop(pkt_drop), .rx_busy(rx_busy));

   router_pkt_rx #(.ADDR_ID(2'd0), .RD_DELAY(2)) dut2 (
      .clock(clock), .reset(reset), .valid_out(v2), .data_out(d2),
      .read_enb(read_enb2), .enable(1'b1), .pld_data(pld_data2), .pld_valid(pld_valid2),
      .pkt_done(pkt_done2), .pkt_len(pkt_len2), .parity_err(parity_err2), .addr_err(addr_err2),
      .pkt_drop(pkt_drop2), .rx_busy(rx_busy2));

   int         nvec = 0, nfail = 0, cyc = 0;
   logic [7:0] fifo[$];
   logic [7:0] rxq[$];
   int         done_cnt = 0, gap_viol = 0;
   logic       d_perr, d_aerr, s_re;
   logic [5:0] d_len;
   logic       hold_v = 1'b0, hold_e = 1'b0;
   int         first2 = -1, drop2_cyc = -1, drop2_cnt = 0, done2_cnt = 0, pld2_cnt = 0;
   logic       busy2_at_drop, perr2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      valid_out = (fifo.size() != 0) && !hold_v;
      enable    = !hold_e;
   endtask

   // One clock: monitor outputs mid-cycle, then model the router after the edge.
   task automatic step();
      logic fire;
      @(negedge clock);
      s_re = read_enb;
      if (pld_valid) rxq.push_back(pld_data);
      if (pkt_done) begin
         done_cnt++; d_perr = parity_err; d_aerr = addr_err; d_len = pkt_len;
      end
      if (read_enb && (!valid_out || !enable)) gap_viol++;
      fire = read_enb && valid_out;
      if (read_enb2 && first2 < 0) first2 = cyc;
      if (pkt_drop2) begin drop2_cnt++; drop2_cyc = cyc; busy2_at_drop = rx_busy2; end
      if (pkt_done2) begin done2_cnt++; perr2 = parity_err2; end
      if (pld_valid2) pld2_cnt++;
      @(posedge clock);
      #1;
      cyc++;
      if (fire && fifo.size() != 0) data_out = fifo.pop_front();
      else                          data_out = 8'hEE;
      refresh();
   endtask

   task automatic push_std(input logic [7:0] par);
      fifo.push_back(8'h10); fifo.push_back(8'h11); fifo.push_back(8'h22);
      fifo.push_back(8'h33); fifo.push_back(8'h44); fifo.push_back(par);
      refresh();
   endtask

   task automatic run_until_done(input int exp, input int budget);
      int n = 0;
      while (done_cnt < exp && n < budget) begin step(); n++; end
      check("pkt_done_count", done_cnt, exp);
   endtask

   task automatic wait_rx(input int cnt, input int budget);
      int n = 0;
      while (rxq.size() < cnt && n < budget) begin step(); n++; end
      check("pld_count_reached", rxq.size(), cnt);
   endtask

   task automatic check_std_payload(input string tag);
      check({tag, "_n"}, rxq.size(), 4);
      if (rxq.size() == 4) begin
         check({tag, "_b0"}, rxq[0], 8'h11);
         check({tag, "_b1"}, rxq[1], 8'h22);
         check({tag, "_b2"}, rxq[2], 8'h33);
         check({tag, "_b3"}, rxq[3], 8'h44);
      end
   endtask

   initial begin
      int         t, n_at_rst, bad;
      logic [7:0] par, b;
      reset = 1'b0; valid_out = 1'b0; enable = 1'b1; data_out = 8'hEE; v2 = 1'b0; d2 = 8'h00;
      repeat (3) step();
      // reset state
      check("rst_rx_busy", rx_busy, 1'b0);
      check("rst_read_enb", read_enb, 1'b0);
      check("rst_pkt_len", pkt_len, 6'd0);
      check("rst_pld_data", pld_data, 8'h00);
      check("rst_errs", {parity_err, addr_err, pkt_done, pkt_drop, pld_valid}, 5'b0);
      reset = 1'b1;
      step();

      // 1: good packet, len 4
      rxq.delete();
      push_std(8'h54);
      run_until_done(1, 100);
      check_std_payload("t1");
      check("t1_len", d_len, 6'd4);
      check("t1_perr", d_perr, 1'b0);
      check("t1_aerr", d_aerr, 1'b0);
      check("t1_idle", rx_busy, 1'b0);

      // 2: bad parity, then good packet clears it
      rxq.delete();
      push_std(8'h55);
      run_until_done(2, 100);
      check("t2_perr", d_perr, 1'b1);
      check_std_payload("t2");
      repeat (3) step();
      check("t2_perr_hold", parity_err, 1'b1);
      rxq.delete();
      push_std(8'h54);
      run_until_done(3, 100);
      check("t2_perr_clr", d_perr, 1'b0);

      // 3: address mismatch, packet still fully drained
      rxq.delete();
      fifo.push_back(8'h11); fifo.push_back(8'h11); fifo.push_back(8'h22);
      fifo.push_back(8'h33); fifo.push_back(8'h44); fifo.push_back(8'h55);
      refresh();
      wait_rx(1, 50);
      check("t3_aerr_live", addr_err, 1'b1);
      run_until_done(4, 100);
      check("t3_aerr", d_aerr, 1'b1);
      check("t3_perr", d_perr, 1'b0);
      check("t3_drained", fifo.size(), 0);
      check_std_payload("t3");

      // 4: len 63 with valid_out and enable gaps
      rxq.delete();
      gap_viol = 0;
      par = 8'hFC;
      fifo.push_back(8'hFC);
      for (int i = 0; i < 63; i++) begin
         b = 8'((i * 7 + 3) & 8'hFF);
         fifo.push_back(b);
         par = par ^ b;
      end
      fifo.push_back(par);
      refresh();
      wait_rx(10, 100);
      hold_v = 1'b1; refresh();
      for (int i = 0; i < 3; i++) begin step(); check("t4_re_vgap", s_re, 1'b0); end
      hold_v = 1'b0; refresh();
      repeat (2) step();
      hold_e = 1'b1; refresh();
      for (int i = 0; i < 3; i++) begin step(); check("t4_re_egap", s_re, 1'b0); end
      hold_e = 1'b0; refresh();
      run_until_done(5, 300);
      check("t4_n", rxq.size(), 63);
      bad = 0;
      if (rxq.size() == 63)
         for (int i = 0; i < 63; i++) if (rxq[i] !== 8'((i * 7 + 3) & 8'hFF)) bad++;
      check("t4_bytes_bad", bad, 0);
      check("t4_perr", d_perr, 1'b0);
      check("t4_len", d_len, 6'd63);
      check("t4_gap_viol", gap_viol, 0);

      // 6: reset mid-packet, then clean packet
      rxq.delete();
      push_std(8'h54);
      wait_rx(2, 50);
      reset = 1'b0;
      step();
      reset = 1'b1;
      fifo.delete(); data_out = 8'hEE; refresh();
      #1;
      n_at_rst = rxq.size();
      check("t6_busy", rx_busy, 1'b0);
      check("t6_re", read_enb, 1'b0);
      check("t6_pld_data", pld_data, 8'h00);
      check("t6_len", pkt_len, 6'd0);
      check("t6_flags", {parity_err, addr_err, pkt_done, pkt_drop, pld_valid}, 5'b0);
      repeat (5) step();
      check("t6_no_done", done_cnt, 5);
      check("t6_no_pld", rxq.size(), n_at_rst);
      rxq.delete();
      push_std(8'h54);
      run_until_done(6, 100);
      check_std_payload("t6");
      check("t6_perr", d_perr, 1'b0);

      // 5: RD_DELAY=2 drop, then first-read latency with a len-0 packet
      v2 = 1'b1; t = cyc;
      repeat (2) step();
      v2 = 1'b0;
      repeat (3) step();
      check("t5_drop_cyc", drop2_cyc, t + 3);
      check("t5_drop_idle", busy2_at_drop, 1'b0);
      check("t5_no_read", first2, -1);
      first2 = -1;
      v2 = 1'b1; t = cyc;
      for (int i = 0; i < 20 && first2 < 0; i++) step();
      check("t5_first_re", first2, t + 4);
      for (int i = 0; i < 20 && done2_cnt == 0; i++) step();
      check("t5_len0_done", done2_cnt, 1);
      check("t5_len0_nopld", pld2_cnt, 0);
      check("t5_len0_perr", perr2, 1'b0);
      check("t5_drop_total", drop2_cnt, 1);
      v2 = 1'b0;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/router_pkt_rx.md
Name: router_pkt_rx

Overview:
- Destination-side packet receiver for one router output port.
- Watches valid_out and issues read_enb to drain the port FIFO.
- Parses header / payload / parity, streams payload bytes downstream and reports per-packet status.
- Used as the synthesizable sink on router outputs and as a reference consumer in system benches.

Parameters:
- ADDR_ID, 2'd0, expected destination address; a header addr field mismatch raises addr_err.
- RD_DELAY, 0, idle cycles inserted between valid_out detection and first read_enb (0..63). Values >= 30 deliberately provoke the router's read-timeout soft reset.

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- valid_out  in  1  router port FIFO non-empty.
- data_out  in  8  router read data; valid one cycle after an accepted read.
- read_enb  out  1  read request to router port.
- enable  in  1  0 = pause issuing reads (back-pressure from downstream).
- pld_data  out  8  captured payload byte.
- pld_valid  out  1  pld_data valid, one-cycle pulse per byte.
- pkt_done  out  1  one-cycle pulse after parity byte captured.
- pkt_len  out  6  length field of last/current header.
- parity_err  out  1  valid with pkt_done; parity mismatch.
- addr_err  out  1  valid from header capture through pkt_done; addr != ADDR_ID.
- pkt_drop  out  1  one-cycle pulse: valid_out fell during WAIT, packet abandoned.
- rx_busy  out  1  1 whenever state != IDLE.

Behaviour:
- Packet format:
  - Header byte: [7:2] = len (0..63), [1:0] = addr.
  - Then len payload bytes.
  - Then parity byte = XOR of header and all payload bytes.
- Accepted read ("fire"): read_enb && valid_out. read_enb = (state in HDR, PLD) && valid_out && enable && reads_left > 0. Combinational from valid_out/enable.
- Read latency is fixed at 1: the byte for a fire in cycle N is sampled from data_out at the clock edge ending cycle N+1.
- Reset (reset==0 at posedge):
  - State goes to IDLE; all counters cleared.
  - Outputs: read_enb=0, pld_valid=0, pkt_done=0, pkt_drop=0, parity_err=0, addr_err=0, pkt_len=0, pld_data=0, rx_busy=0.
  - Reset mid-packet abandons the packet. No pulses are generated and no state is retained.
- States:
  - IDLE: valid_out=1 -> WAIT, loading dly_cnt=RD_DELAY.
  - WAIT: decrement dly_cnt each cycle.
    - valid_out=0 -> pulse pkt_drop, go to IDLE.
    - dly_cnt==0 -> HDR.
  - HDR: one read (reads_left=1). On fire -> HCAP.
  - HCAP: latch data_out as header.
    - pkt_len <= len; addr_err <= (addr != ADDR_ID); par_acc <= header.
    - reads_left <= len+1; cap_cnt <= 0; go to PLD.
    - One bubble cycle is required here.
  - PLD: issue reads while reads_left>0 (decrement on fire). Each captured byte (fire delayed 1 cycle) is handled as:
    - cap_cnt < len: pld_data <= byte, pld_valid=1, par_acc ^= byte, cap_cnt++.
    - cap_cnt == len: parity_err <= (par_acc != byte), pkt_done=1, go to IDLE.
- valid_out or enable low mid-packet: read_enb drops and all state holds. Resume on return with no byte loss or duplication. There is no timeout.
- len==0: reads_left=1; only the parity byte is read and pkt_done follows; no pld_valid.
- A new packet may be detected on the cycle after pkt_done (IDLE sees valid_out).
- parity_err and addr_err hold until the next HCAP or reset.

Decomposition:
- Shared package router_pkt_pkg:
  - Header field positions (LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1, ADDR_LSB=0).
  - MAX_LEN=63.
  - RD_TIMEOUT=30.
  - rx_state_e enum {IDLE, WAIT, HDR, HCAP, PLD}.
  - Header-pack function (pack len/addr into a byte), reused by TX-side benches.
- Single module; no natural sub-module.

Test Plan:
1. Header 0x10, payload 11 22 33 44, parity 0x54, RD_DELAY=0 -> pld_valid x4 with bytes 11,22,33,44 in order; pkt_done with pkt_len=4, parity_err=0, addr_err=0.
2. Same packet with parity 0x55 -> pkt_done with parity_err=1; the following correct packet clears parity_err=0.
3. Header 0x11 (len 4, addr 1), ADDR_ID=0 -> addr_err=1 from HCAP; all 6 bytes still drained; pkt_done asserted.
4. len=63 packet with valid_out forced low 3 cycles after the 10th payload byte and enable low 2 cycles later -> read_enb low during both gaps; exactly 63 pld_valid pulses; parity_err=0.
5. RD_DELAY=2, valid_out rises at cycle T -> read_enb first high at T+4. Separately, valid_out drops at T+2 -> pkt_drop pulse at T+3 and state returns to IDLE.
6. reset low for 1 cycle after the 2nd payload byte -> next cycle all outputs are 0 with rx_busy=0; no pkt_done; the next packet is received cleanly.
